// File: rtl/tile_map_if.sv
// Map-load channel between the renderer and the external map ROM.
// load_req is a one-cycle request taken only while busy is low; rom_data answers rom_addr one cycle later.
interface tile_map_if #(
   parameter int MAP_W    = 40,
   parameter int MAP_H    = 40,
   parameter int NUM_MAPS = 3
);
   localparam int SEL_W = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
   localparam int AW    = $clog2(NUM_MAPS * MAP_H);

   logic             load_req;
   logic [SEL_W-1:0] map_sel;
   logic [AW-1:0]    rom_addr;
   logic [MAP_W-1:0] rom_data;
   logic             busy;

   modport master (output load_req, map_sel, rom_data, input rom_addr, busy);
   modport slave  (input load_req, map_sel, rom_data, output rom_addr, busy);
endinterface

// File: rtl/tile_map_renderer.sv
// Tile-map wall renderer: ROM-loaded wall bitmap, runtime door writes,
// collision queries and a 2-stage pixel path producing texture addresses.
module tile_map_renderer #(
   parameter int MAP_W    = 40,
   parameter int MAP_H    = 40,
   parameter int TILE     = 5,
   parameter int ORG_X    = 60,
   parameter int ORG_Y    = 30,
   parameter int TEX_ROW  = 120,
   parameter int FB_W     = 320,
   parameter int NUM_MAPS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        render_en,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   output logic [16:0] pixel_addr,
   output logic        isObject,
   tile_map_if.slave   ld,
   input  logic        wr_en,
   input  logic [5:0]  wr_x,
   input  logic [5:0]  wr_y,
   input  logic        wr_val,
   input  logic [5:0]  q_x,
   input  logic [5:0]  q_y,
   output logic        q_wall,
   output logic [1:0]  dbg_state
);
   localparam int SEL_W = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
   localparam int AW    = $clog2(NUM_MAPS * MAP_H);
   localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
   localparam int TM_W  = (TILE > 1) ? $clog2(TILE) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} load_state_t;

   load_state_t      state_q, state_d;
   logic [ROW_W-1:0] row_q;
   logic [AW-1:0]    base_q;
   logic [SEL_W-1:0] sel_c;
   logic             busy;
   logic             wr_ok;
   logic             q_in;
   logic [MAP_W-1:0] map_q [MAP_H];

   assign busy      = (state_q != IDLE);
   assign ld.busy   = busy;
   assign dbg_state = state_q;
   assign ld.rom_addr = (state_q == FETCH || state_q == WRITE) ? (base_q + AW'(row_q)) : '0;

   always_comb begin
      sel_c = ld.map_sel;
      if (32'(ld.map_sel) >= NUM_MAPS) sel_c = SEL_W'(NUM_MAPS - 1);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ld.load_req) state_d = FETCH;
         FETCH:   state_d = WRITE;
         WRITE:   state_d = (row_q == ROW_W'(MAP_H - 1)) ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && ld.load_req) begin
            row_q  <= '0;
            base_q <= AW'(32'(sel_c) * MAP_H);
         end else if (state_q == WRITE) begin
            row_q <= row_q + 1'b1;
         end
      end
   end

   // A load_req in the same cycle wins over a tile write.
   assign wr_ok = wr_en && !busy && !ld.load_req &&
                  (32'(wr_x) < MAP_W) && (32'(wr_y) < MAP_H);
   assign q_in  = (32'(q_x) < MAP_W) && (32'(q_y) < MAP_H);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < MAP_H; r++) map_q[r] <= '0;
      end else if (state_q == WRITE) begin
         map_q[row_q] <= ld.rom_data;
      end else if (wr_ok) begin
         map_q[wr_y][wr_x] <= wr_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_wall <= 1'b1;
      else        q_wall <= (busy || !q_in) ? 1'b1 : map_q[q_y][q_x];
   end

   logic [31:0]     x_c, y_c, dx_c, dy_c;
   logic            in_win;
   logic            s1_hit;
   logic [5:0]      s1_col, s1_row;
   logic [TM_W-1:0] s1_xm, s1_ym;
   logic            tile_bit;
   logic [31:0]     addr_c;

   always_comb begin
      x_c    = 32'(h_cnt) >> 1;
      y_c    = 32'(v_cnt) >> 1;
      dx_c   = x_c - 32'(ORG_X);
      dy_c   = y_c - 32'(ORG_Y);
      in_win = (x_c >= 32'(ORG_X)) && (x_c < 32'(ORG_X + MAP_W * TILE)) &&
               (y_c >= 32'(ORG_Y)) && (y_c < 32'(ORG_Y + MAP_H * TILE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit <= 1'b0;
         s1_col <= '0;
         s1_row <= '0;
         s1_xm  <= '0;
         s1_ym  <= '0;
      end else begin
         s1_hit <= render_en && !busy && in_win;
         s1_col <= in_win ? 6'(dx_c / 32'(TILE)) : 6'd0;
         s1_row <= in_win ? 6'(dy_c / 32'(TILE)) : 6'd0;
         s1_xm  <= TM_W'(x_c % 32'(TILE));
         s1_ym  <= TM_W'(y_c % 32'(TILE));
      end
   end

   // The map is read here, before any write landing on this same edge.
   assign tile_bit = map_q[s1_row][s1_col];
   assign addr_c   = 32'(s1_xm) + (32'(s1_ym) + 32'(TEX_ROW)) * 32'(FB_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isObject   <= 1'b0;
         pixel_addr <= '0;
      end else begin
         isObject   <= s1_hit && tile_bit;
         pixel_addr <= (s1_hit && tile_bit) ? addr_c[16:0] : 17'd0;
      end
   end
endmodule
